// File: rtl/sqrt_ctrl.sv
// Control FSM for the 8-bit odd-sum integer square-root unit.
// Sequences sqrt_proc through the d/s update states and reports completion.
//
//  state          | meaning
//  ---------------+------------------------------------------------
//  idle           | waiting for start_i
//  get_x          | datapath loads x; iteration count cleared
//  test           | compare s against x, no datapath action
//  sumd_load_r1   | d update, load first operand
//  sumd_load_r2   | d update, load second operand
//  sumd_drive     | d update, write d + 2
//  sums_load_r1   | s update, load first operand
//  sums_load_r2_1 | s update, load d
//  sums_drive_r1  | s update, write partial sum
//  sums_load_r2_2 | s update, load constant
//  sums_drive     | s update, write s + d + 1
//  zero           | x == 0 shortcut
//  finaliza       | loop exit, result ready next step
module sqrt_ctrl #(
    parameter int ITER_W = 5
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              enb_i,
    input  logic              start_i,
    input  logic [8:0]        d,
    input  logic [8:0]        s,
    input  logic [7:0]        x,
    output logic [3:0]        state,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_o
);

    typedef enum logic [3:0] {
        idle           = 4'd0,
        get_x          = 4'd1,
        test           = 4'd2,
        sumd_load_r1   = 4'd3,
        sumd_load_r2   = 4'd4,
        sumd_drive     = 4'd5,
        sums_load_r1   = 4'd6,
        sums_load_r2_1 = 4'd7,
        sums_drive_r1  = 4'd8,
        sums_load_r2_2 = 4'd9,
        sums_drive     = 4'd10,
        zero           = 4'd11,
        finaliza       = 4'd12
    } state_e;

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    // d is wired in for debug visibility only; the loop decision needs s and x.
    logic unused_d;
    assign unused_d = ^d;

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        done_d  = 1'b0;
        case (state_q)
            idle:           if (start_i) state_d = get_x;
            get_x: begin
                state_d = test;
                iter_d  = '0;
            end
            test: begin
                if (x == 8'd0)
                    state_d = zero;
                else if (s <= {1'b0, x})
                    state_d = sumd_load_r1;
                else
                    state_d = finaliza;
            end
            sumd_load_r1:   state_d = sumd_load_r2;
            sumd_load_r2:   state_d = sumd_drive;
            sumd_drive:     state_d = sums_load_r1;
            sums_load_r1:   state_d = sums_load_r2_1;
            sums_load_r2_1: state_d = sums_drive_r1;
            sums_drive_r1:  state_d = sums_load_r2_2;
            sums_load_r2_2: state_d = sums_drive;
            sums_drive: begin
                state_d = test;
                if (!(&iter_q)) iter_d = iter_q + ITER_W'(1);
            end
            zero, finaliza: begin
                state_d = idle;
                done_d  = 1'b1;
            end
            default:        state_d = idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= idle;
            done_q  <= 1'b0;
            iter_q  <= '0;
        end else if (enb_i) begin
            state_q <= state_d;
            done_q  <= done_d;
            iter_q  <= iter_d;
        end
    end

    assign state  = state_q;
    assign done_o = done_q;
    assign iter_o = iter_q;

endmodule
